// File: rtl/csa_mant_mul.sv
// csa_mant_mul -- sequential unsigned mantissa multiplier built around a
// single row of full-adder (carry-save) cells. One partial product is folded
// into the redundant sum/carry pair per cycle; a final carry-propagate add
// resolves the pair into the product register.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair presented (sampled only in IDLE)
//   in_ready   high only in IDLE
//   a, b       unsigned WIDTH-bit mantissas (hidden bit included)
//   out_valid  product available, held until out_ready
//   out_ready  downstream accepts the product (looked at only in DONE)
//   product    registered 2*WIDTH-bit a*b
//   busy       high in every state except IDLE
//
// state   | meaning
// IDLE    | waiting for an operand pair
// MUL     | one carry-save step per cycle, WIDTH steps
// RESOLVE | sum + carry into the product register
// DONE    | product held until out_ready

module csa_mant_mul #(
  parameter int WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, RESOLVE, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   a_shift;   // a_reg << i for the current step i
  logic [WIDTH-1:0] b_shift;  // b_reg >> i, so bit 0 is b_reg[i]
  logic [PW-1:0]   sum;
  logic [PW-1:0]   carry;
  logic [CW-1:0]   cnt;

  logic [PW-1:0]   pp;
  logic [PW-1:0]   csa_sum;
  logic [PW-1:0]   csa_carry;

  always_comb begin
    pp        = b_shift[0] ? a_shift : '0;
    csa_sum   = sum ^ carry ^ pp;
    // majority shifted up one weight; the MSB carry falls off because the
    // exact product always fits in PW bits
    csa_carry = ((sum & carry) | (sum & pp) | (carry & pp)) << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_shift   <= '0;
      b_shift   <= '0;
      sum       <= '0;
      carry     <= '0;
      cnt       <= '0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_shift <= {{WIDTH{1'b0}}, a};
            b_shift <= b;
            sum     <= '0;
            carry   <= '0;
            cnt     <= '0;
            state   <= MUL;
          end
        end
        MUL: begin
          sum     <= csa_sum;
          carry   <= csa_carry;
          a_shift <= a_shift << 1;
          b_shift <= b_shift >> 1;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) state <= RESOLVE;
        end
        RESOLVE: begin
          product   <= sum + carry;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_csa_mant_mul.sv
module tb_csa_mant_mul;

  localparam int W  = 24;
  localparam int PW = 48;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  int passed = 0;
  int total  = 0;

  csa_mant_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Presents one pair from IDLE, then waits (bounded) for out_valid.
  // lat = cycles from acceptance edge to out_valid, -1 on timeout.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output logic [PW-1:0] prod);
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    prod = product;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (product !== 48'h0) $display("FAIL reset_product: got %h expected 0", product); else passed++;
  endtask

  task automatic test_unit();
    int lat; logic [PW-1:0] p;
    out_ready = 1'b1;
    run_op(24'h000001, 24'h000001, lat, p);
    total++; if (lat !== LAT) $display("FAIL unit_latency: got %0d expected %0d", lat, LAT); else passed++;
    total++; if (p !== 48'h000000000001) $display("FAIL unit_product: got %h expected 000000000001", p); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL unit_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_all_ones();
    int lat; logic [PW-1:0] p;
    out_ready = 1'b1;
    run_op(24'hFFFFFF, 24'hFFFFFF, lat, p);
    total++; if (p !== 48'hFFFFFE000001) $display("FAIL ones_product: got %h expected fffffe000001", p); else passed++;
    total++; if (lat !== LAT) $display("FAIL ones_latency: got %0d expected %0d", lat, LAT); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int lat; logic [PW-1:0] p;
    out_ready = 1'b1;
    run_op(24'h800000, 24'h000000, lat, p);
    total++; if (p !== 48'h0) $display("FAIL zero_product: got %h expected 0", p); else passed++;
    total++; if (lat !== LAT) $display("FAIL zero_latency: got %0d expected %0d", lat, LAT); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; logic [PW-1:0] p;
    int bad;
    out_ready = 1'b0;
    run_op(24'hC00000, 24'hA00000, lat, p);
    total++; if (lat !== LAT) $display("FAIL bp_latency: got %0d expected %0d", lat, LAT); else passed++;
    total++; if (p !== 48'h780000000000) $display("FAIL bp_product: got %h expected 780000000000", p); else passed++;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || product !== 48'h780000000000 || in_ready !== 1'b0) begin
        $display("FAIL bp_hold: cycle %0d got out_valid=%b product=%h in_ready=%b expected 1/780000000000/0",
                 c, out_valid, product, in_ready);
        bad++;
      end else passed++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_ignore();
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 24'h000003;
    b = 24'h000003;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 3) begin
        in_valid = 1'b1;
        a = 24'hFFFFFF;
        b = 24'hFFFFFF;
      end
      if (c == 6) in_valid = 1'b0;
      @(posedge clk); #1;
      if (c == 3) begin
        total++; if (in_ready !== 1'b0 || busy !== 1'b1)
          $display("FAIL ignore_busy: got in_ready=%b busy=%b expected 0/1", in_ready, busy); else passed++;
      end
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    total++; if (lat !== LAT) $display("FAIL ignore_latency: got %0d expected %0d", lat, LAT); else passed++;
    total++; if (product !== 48'h000000000009) $display("FAIL ignore_product: got %h expected 000000000009", product); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [PW-1:0] p; int seen;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 24'h123456;
    b = 24'h654321;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || product !== 48'h0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL abort_outputs: got out_valid=%b product=%h in_ready=%b busy=%b expected 0/0/1/0",
               out_valid, product, in_ready, busy); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    total++; if (seen !== 0) $display("FAIL abort_no_output: got %0d active cycles expected 0", seen); else passed++;
    // acceptance on the first edge after reset release
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(24'h000005, 24'h000007, lat, p);
    total++; if (lat !== LAT) $display("FAIL first_edge_latency: got %0d expected %0d", lat, LAT); else passed++;
    total++; if (p !== 48'd35) $display("FAIL first_edge_product: got %h expected 000000000023", p); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic [PW-1:0] p; logic [PW-1:0] exp_p;
    logic [W-1:0] av, bv;
    int waitc;
    for (int n = 0; n < 1500; n++) begin
      av = W'($urandom);
      bv = W'($urandom);
      if (n == 0) av = 24'hFFFFFF;
      if (n == 1) bv = 24'h000000;
      exp_p = {24'h0, av} * {24'h0, bv};
      out_ready = $urandom_range(0, 1) == 1;
      run_op(av, bv, lat, p);
      total++; if (lat !== LAT || p !== exp_p)
        $display("FAIL rand_product: pair %0d a=%h b=%h got %h lat %0d expected %h lat %0d",
                 n, av, bv, p, lat, exp_p, LAT); else passed++;
      if (!out_ready) begin
        waitc = $urandom_range(0, 3);
        repeat (waitc) begin @(posedge clk); #1; end
        total++; if (out_valid !== 1'b1 || product !== exp_p)
          $display("FAIL rand_hold: pair %0d got out_valid=%b product=%h expected 1/%h",
                   n, out_valid, product, exp_p); else passed++;
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_unit();
    test_all_ones();
    test_zero();
    test_backpressure();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
